// File: rtl/dca_matrix_wdata_aligner.sv
// ---------------------------------------------------------------------------
// dca_matrix_wdata_aligner
//
// Multi-beat write-data aligner for the DCA matrix LSU store path. A header
// (bit offset, element size, beat count) opens a transaction. Each row-buffer
// beat is then shifted up by the offset and emitted as a memory-aligned beat
// with a per-bit write mask. Bits pushed past the top of a beat are carried
// into the next beat. If the last input beat leaves carried mask bits, one
// extra flush beat is emitted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clear             synchronous abort (same effect as rst)
//   txn_*             header channel (valid/ready)
//   in_*              row-buffer beat channel (valid/ready)
//   out_*             aligned beat channel to the W-channel packer (valid/ready)
//   busy              transaction open or output beat pending
//   dbg_state         current FSM state, for checkers
//
// Handshake rule, all channels: a transfer happens on a rising clk edge where
// valid && ready. Once valid is raised, the source holds the payload stable
// until that transfer. ready may depend combinationally on the sink's state.
// in_ready also depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module dca_matrix_wdata_aligner #(
    parameter int BW_DATA         = 128,
    parameter bit SUPPORT_SUBBYTE = 1'b0,
    parameter int BW_OFFSET       = $clog2(BW_DATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 txn_valid,
    output logic                 txn_ready,
    input  logic [BW_OFFSET-1:0] txn_offset,
    input  logic [2:0]           txn_elem_log2,
    input  logic [7:0]           txn_num_beats_m1,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BW_DATA-1:0]   in_data,
    input  logic [BW_DATA-1:0]   in_emask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW_DATA-1:0]   out_data,
    output logic [BW_DATA-1:0]   out_bmask,
    output logic                 out_last,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [BW_OFFSET-1:0] SUBBYTE_BITS = BW_OFFSET'(7);

    state_t                 state_q, state_d;
    logic [BW_OFFSET-1:0]   off_q;
    logic [2:0]             elem_log2_q;
    logic [7:0]             beat_cnt_q;
    logic [BW_DATA-1:0]     carry_data_q, carry_mask_q;

    logic                   reg_free;
    logic                   txn_fire, in_fire;
    logic [BW_OFFSET-1:0]   off_in;
    logic [2:0]             elem_log2_in;
    logic [BW_DATA-1:0]     xmask;
    logic [2*BW_DATA-1:0]   sh_data, sh_mask;
    logic [BW_DATA-1:0]     lo_d, hi_d, lo_m, hi_m;

    // The output register can take a new beat when empty or draining now.
    assign reg_free  = !out_valid || out_ready;
    assign txn_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_STREAM) && reg_free;
    assign busy      = (state_q != S_IDLE) || out_valid;
    assign dbg_state = state_q;

    // clear wins over any handshake presented in the same cycle.
    assign txn_fire = txn_valid && txn_ready && !clear;
    assign in_fire  = in_valid && in_ready && !clear;

    // Byte-granular destinations only, unless sub-byte offsets are enabled.
    assign off_in = SUPPORT_SUBBYTE ? txn_offset : (txn_offset & ~SUBBYTE_BITS);
    // Element sizes above 32 bits are not defined; saturate to 32.
    assign elem_log2_in = (txn_elem_log2 > 3'd5) ? 3'd5 : txn_elem_log2;

    // Expand the element mask to one bit per data bit.
    always_comb begin
        logic [BW_OFFSET-1:0] idx;
        xmask = '0;
        idx   = '0;
        for (int i = 0; i < BW_DATA; i++) begin
            idx      = BW_OFFSET'(i) >> elem_log2_q;
            xmask[i] = in_emask[idx];
        end
    end

    // Double-width shift: the low half lands in this beat, the high half is
    // what spills over into the next one.
    assign sh_data = {{BW_DATA{1'b0}}, in_data} << off_q;
    assign sh_mask = {{BW_DATA{1'b0}}, xmask} << off_q;
    assign lo_d    = sh_data[BW_DATA-1:0];
    assign hi_d    = sh_data[2*BW_DATA-1:BW_DATA];
    assign lo_m    = sh_mask[BW_DATA-1:0];
    assign hi_m    = sh_mask[2*BW_DATA-1:BW_DATA];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (txn_fire) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (in_fire && (beat_cnt_q == 8'd0)) begin
                    state_d = (hi_m != '0) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (reg_free) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= S_IDLE;
            off_q        <= '0;
            elem_log2_q  <= '0;
            beat_cnt_q   <= '0;
            carry_data_q <= '0;
            carry_mask_q <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            out_bmask    <= '0;
        end else begin
            state_q <= state_d;

            if (out_valid && out_ready) out_valid <= 1'b0;

            if (txn_fire) begin
                off_q        <= off_in;
                elem_log2_q  <= elem_log2_in;
                beat_cnt_q   <= txn_num_beats_m1;
                carry_data_q <= '0;
                carry_mask_q <= '0;
            end

            if (in_fire) begin
                out_valid    <= 1'b1;
                out_data     <= lo_d | carry_data_q;
                out_bmask    <= lo_m | carry_mask_q;
                carry_data_q <= hi_d;
                carry_mask_q <= hi_m;
                if (beat_cnt_q != 8'd0) begin
                    beat_cnt_q <= beat_cnt_q - 8'd1;
                    out_last   <= 1'b0;
                end else begin
                    // Last input beat closes the transaction only if
                    // nothing spilled past the top of the beat.
                    out_last <= (hi_m == '0);
                end
            end

            if ((state_q == S_FLUSH) && reg_free) begin
                out_valid    <= 1'b1;
                out_data     <= carry_data_q;
                out_bmask    <= carry_mask_q;
                out_last     <= 1'b1;
                carry_data_q <= '0;
                carry_mask_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_wdata_aligner.sv
// ---------------------------------------------------------------------------
// tb_dca_matrix_wdata_aligner
//
// Bench for dca_matrix_wdata_aligner at BW_DATA=32, SUPPORT_SUBBYTE=0.
// Drivers push expected output beats ({last, mask, data}) from a bit-level
// model when an input beat is accepted; a negedge monitor pops and compares
// them whenever an output beat transfers.
// ---------------------------------------------------------------------------
module tb_dca_matrix_wdata_aligner;

    localparam int W   = 32;
    localparam int OW  = 5;
    localparam int TMO = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clear = 1'b0;
    logic          txn_valid = 1'b0;
    logic          txn_ready;
    logic [OW-1:0] txn_offset = '0;
    logic [2:0]    txn_elem_log2 = '0;
    logic [7:0]    txn_num_beats_m1 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_emask = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [W-1:0]  out_bmask;
    logic          out_last;
    logic          busy;
    logic [1:0]    dbg_state;

    dca_matrix_wdata_aligner #(
        .BW_DATA(W),
        .SUPPORT_SUBBYTE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_offset(txn_offset),
        .txn_elem_log2(txn_elem_log2), .txn_num_beats_m1(txn_num_beats_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_emask(in_emask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bmask(out_bmask), .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [2*W:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int           m_off;
    int           m_elog;
    int           m_cnt;
    logic [W-1:0] m_cd, m_cm;

    function automatic logic [W-1:0] expand(input logic [W-1:0] emask, input int elog);
        logic [W-1:0] xm;
        int esz;
        xm  = '0;
        esz = 1 << elog;
        for (int k = 0; k < W; k++)
            if (emask[k])
                for (int b = 0; b < esz; b++)
                    if (k * esz + b < W) xm[k * esz + b] = 1'b1;
        return xm;
    endfunction

    task automatic model_beat(input logic [W-1:0] d, input logic [W-1:0] em);
        logic [2*W-1:0] sd, sm;
        logic           last;
        sd = {{W{1'b0}}, d} << m_off;
        sm = {{W{1'b0}}, expand(em, m_elog)} << m_off;
        last = (m_cnt == 0) && (sm[2*W-1:W] == '0);
        exp_q.push_back({last, sm[W-1:0] | m_cm, sd[W-1:0] | m_cd});
        m_cd = sd[2*W-1:W];
        m_cm = sm[2*W-1:W];
        if (m_cnt == 0) begin
            if (m_cm != '0) exp_q.push_back({1'b1, m_cm, m_cd});
            m_cd = '0;
            m_cm = '0;
        end else begin
            m_cnt--;
        end
    endtask

    // ---------------- monitor ----------------
    logic         hold_v = 1'b0;
    logic [127:0] hold_val;
    logic [2*W:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_v)
                check("hold_stable", {out_valid, out_last, out_bmask, out_data}, hold_val);
            hold_v   = out_valid && !out_ready && !clear;
            hold_val = {out_valid, out_last, out_bmask, out_data};
            if (out_valid && out_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("out_bmask", out_bmask, e[2*W-1:W]);
                    check("out_last", out_last, e[2*W]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_txn(input int off, input int elog, input int nbm1);
        int t = 0;
        txn_offset       = OW'(off);
        txn_elem_log2    = 3'(elog);
        txn_num_beats_m1 = 8'(nbm1);
        txn_valid        = 1'b1;
        @(negedge clk);
        while (!txn_ready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check("txn_timeout", 1, 0);
        @(posedge clk); #1;
        txn_valid = 1'b0;
        m_off  = off & ~7;
        m_elog = (elog > 5) ? 5 : elog;
        m_cnt  = nbm1;
        m_cd   = '0;
        m_cm   = '0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] em);
        int t = 0;
        in_data  = d;
        in_emask = em;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check("beat_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (t < TMO) model_beat(d, em);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid || dbg_state != 2'd0) && t < TMO) begin
            @(negedge clk); t++;
        end
        if (t >= TMO) check("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    logic rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_txn_ready", txn_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bmask", out_bmask, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;

        // aligned, two beats
        send_txn(0, 3, 1);
        send_beat(32'h44332211, 32'hF);
        send_beat(32'h88776655, 32'hF);
        drain();

        // unaligned with flush
        send_txn(8, 3, 0);
        send_beat(32'h44332211, 32'hF);
        drain();

        // unaligned, no flush
        send_txn(8, 3, 0);
        send_beat(32'h44332211, 32'h7);
        drain();
        @(negedge clk);
        check("s3_idle_txn_ready", txn_ready, 1);
        check("s3_idle_busy", busy, 0);
        @(posedge clk); #1;

        // halfword mask expansion
        send_txn(0, 4, 0);
        send_beat(32'hDEADBEEF, 32'h1);
        drain();

        // backpressure mid-stream
        fork
            begin
                send_txn(8, 3, 3);
                for (int i = 0; i < 4; i++) send_beat($urandom, 32'hF);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!out_valid && t < TMO) begin @(negedge clk); t++; end
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // clear mid-stream with a pending beat and live carry
        out_ready = 1'b0;
        send_txn(8, 3, 1);
        send_beat(32'hA5A5A5A5, 32'hF);
        @(negedge clk);
        check("clr_pre_out_valid", out_valid, 1);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("clr_out_valid", out_valid, 0);
        check("clr_txn_ready", txn_ready, 1);
        check("clr_busy", busy, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        send_txn(0, 3, 0);
        send_beat(32'h12345678, 32'hF);
        drain();

        // randomized transactions, random backpressure, oversize elem_log2
        rand_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int nb;
            nb = $urandom_range(0, 3);
            send_txn(8 * $urandom_range(0, 3) + $urandom_range(0, 7), $urandom_range(0, 7), nb);
            for (int b = 0; b <= nb; b++) send_beat($urandom, $urandom);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
